// File: rtl/fifo_byte_packer_pkg.sv
// Shared types and helpers for the FIFO byte packer: default geometry, FSM states
// and the lane-keep mask generator.
package fifo_pkg;

    localparam int IN_W_DEFAULT  = 8;
    localparam int LANES_DEFAULT = 4;

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    // Mask with the low 'fill' bits set; fill==LANES yields all-ones after truncation.
    function automatic logic [63:0] keep_mask(input int unsigned fill);
        logic [63:0] mask;
        if (fill >= 32'd64) begin
            mask = {64{1'b1}};
        end else begin
            mask = (64'd1 << fill) - 64'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/fifo_byte_packer_slot.sv
// Output holding register for the packer: loads a word when free, holds it stable
// while the consumer stalls and releases it on accept.
module fifo_byte_packer_slot
    import fifo_pkg::*;
#(
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic [K-1:0] load_keep,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic [K-1:0] keep,
    output logic         free
);

    logic         valid_r;
    logic [W-1:0] data_r;
    logic [K-1:0] keep_r;

    // Slot can take a new word when empty or when its current word leaves this cycle.
    assign free  = !valid_r || ready;
    assign valid = valid_r;
    assign data  = data_r;
    assign keep  = keep_r;

    // Holding register: reload, drop valid after accept, or hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
            keep_r  <= {K{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            keep_r  <= load_keep;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains a byte FIFO and packs LANES entries per output word on a valid/ready stream;
// a flush pulse emits the partially collected word with a lane-keep mask.
module fifo_byte_packer
    import fifo_pkg::*;
#(
    parameter int IN_W  = IN_W_DEFAULT,
    parameter int LANES = LANES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [IN_W-1:0]       fifo_rdata,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IN_W*LANES-1:0] m_data,
    output logic [LANES-1:0]      m_keep
);

    localparam int OUT_W  = IN_W * LANES;
    localparam int IDX_W  = $clog2(LANES);
    localparam int FILL_W = IDX_W + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LANES);
    localparam logic [FILL_W:0]   LANES_EXT = (FILL_W + 1)'(LANES);

    state_t             state_r;
    state_t             state_s;
    logic [FILL_W-1:0]  fill_r;
    logic               inflight_r;
    logic [OUT_W-1:0]   asm_r;
    logic [FILL_W:0]    pending_s;
    logic               rd_en_s;
    logic               slot_free_s;
    logic               full_xfer_s;
    logic               flush_xfer_s;
    logic               load_s;
    logic [LANES-1:0]   keep_s;

    assign pending_s  = {1'b0, fill_r} + {{FILL_W{1'b0}}, inflight_r};
    assign fifo_rd_en = rd_en_s;

    // Read issue: counting the in-flight entry keeps assembly from overflowing.
    always_comb begin
        rd_en_s = !rst && !fifo_empty && (state_r == S_FILL) && (pending_s < LANES_EXT);
    end

    // Full words move whenever the slot frees; partial words only once the flush has settled.
    always_comb begin
        full_xfer_s  = (fill_r == FILL_FULL) && slot_free_s;
        flush_xfer_s = (state_r == S_FLUSH) && !inflight_r &&
                       (fill_r != {FILL_W{1'b0}}) && slot_free_s;
        load_s       = full_xfer_s || flush_xfer_s;
        keep_s       = LANES'(keep_mask(32'(fill_r)));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_FILL: begin
                if (flush) begin
                    state_s = S_FLUSH;
                end else begin
                    state_s = S_FILL;
                end
            end
            S_FLUSH: begin
                if (!inflight_r && ((fill_r == {FILL_W{1'b0}}) || slot_free_s)) begin
                    state_s = S_FILL;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            default: state_s = S_FILL;
        endcase
    end

    // State, in-flight flag and assembly register; a transfer clears every lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_FILL;
            inflight_r <= 1'b0;
            fill_r     <= {FILL_W{1'b0}};
            asm_r      <= {OUT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            inflight_r <= rd_en_s;
            if (load_s) begin
                fill_r <= {FILL_W{1'b0}};
                asm_r  <= {OUT_W{1'b0}};
            end else if (inflight_r) begin
                asm_r[fill_r[IDX_W-1:0]*IN_W +: IN_W] <= fifo_rdata;
                fill_r <= fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
            end else begin
                fill_r <= fill_r;
            end
        end
    end

    fifo_byte_packer_slot #(
        .W (OUT_W),
        .K (LANES)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (asm_r),
        .load_keep (keep_s),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .keep      (m_keep),
        .free      (slot_free_s)
    );

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: FIFO read-side model, output capture,
// a table of single-word vectors and hand-written multi-cycle corner sequences.
module tb_fifo_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    int n_vec  = 0;
    int n_miss = 0;

    fifo_byte_packer dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep)
    );

    always #5 clk = ~clk;

    // FIFO read-side model: registered data_out, one entry per read strobe.
    logic [7:0] mem [256];
    int wr_ptr    = 0;
    int rd_ptr    = 0;
    int underflow = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (wr_ptr == rd_ptr) underflow <= underflow + 1;
            fifo_rdata <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Capture every accepted output word.
    logic [31:0] out_data [64];
    logic [3:0]  out_keep [64];
    int out_cnt = 0;

    always @(posedge clk) begin
        if (!rst && m_valid && m_ready) begin
            out_data[out_cnt[5:0]] <= m_data;
            out_keep[out_cnt[5:0]] <= m_keep;
            out_cnt <= out_cnt + 1;
        end
    end

    typedef struct {
        int          n;
        logic [31:0] bytes;   // push order: bits [31:24] first
        logic        fl;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 100 && wr_ptr != rd_ptr; i++) @(negedge clk);
        check("drain", 32'(rd_ptr), 32'(wr_ptr));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 60 && out_cnt < n; i++) @(negedge clk);
        check("word_count", 32'(out_cnt), 32'(n));
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic check_word(input string name, input int idx,
                              input logic [31:0] d, input logic [3:0] k);
        check({name, "_data"}, out_data[idx[5:0]], d);
        check({name, "_keep"}, 32'(out_keep[idx[5:0]]), 32'(k));
    endtask

    initial begin
        int base;
        int c;

        vt[0] = '{4, 32'h11223344, 1'b0, 32'h44332211, 4'hF};
        vt[1] = '{4, 32'h55667788, 1'b0, 32'h88776655, 4'hF};
        vt[2] = '{3, 32'hA1B2C300, 1'b1, 32'h00C3B2A1, 4'h7};
        vt[3] = '{4, 32'hDEADBEEF, 1'b0, 32'hEFBEADDE, 4'hF};
        vt[4] = '{1, 32'h7E000000, 1'b1, 32'h0000007E, 4'h1};
        vt[5] = '{2, 32'h01020000, 1'b1, 32'h00000201, 4'h3};
        vt[6] = '{4, 32'hCAFEF00D, 1'b1, 32'h0DF0FECA, 4'hF};

        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        push(8'h5A);

        // Reset with a non-empty FIFO: no reads, cleared output slot.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_valid", 32'(m_valid), 32'd0);
            check("rst_data", m_data, 32'h0);
            check("rst_keep", 32'(m_keep), 32'd0);
        end
        rst = 1'b0;

        wait_drained();
        pulse_flush();
        wait_words(1);
        check_word("after_rst", 0, 32'h0000005A, 4'h1);

        // Table of single-word vectors.
        for (int v = 0; v < 7; v++) begin
            c = out_cnt;
            for (int i = 0; i < vt[v].n; i++) push(vt[v].bytes[31 - 8*i -: 8]);
            if (vt[v].fl) begin
                wait_drained();
                pulse_flush();
            end
            wait_words(c + 1);
            check_word($sformatf("vec%0d", v), c, vt[v].exp_data, vt[v].exp_keep);
        end
        repeat (10) @(negedge clk);
        check("no_extra_word", 32'(out_cnt), 32'(8));

        // Flush with nothing collected.
        c = out_cnt;
        pulse_flush();
        repeat (10) @(negedge clk);
        check("flush_empty_cnt", 32'(out_cnt), 32'(c));
        check("flush_empty_valid", 32'(m_valid), 32'd0);

        // Flush while a read is in flight: that byte lands in the partial word.
        c = out_cnt;
        @(negedge clk);
        push(8'h9C);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_words(c + 1);
        check_word("flush_inflight", c, 32'h0000009C, 4'h1);

        // Backpressure: 12 bytes queued, consumer stalled.
        c = out_cnt;
        base = rd_ptr;
        m_ready = 1'b0;
        for (int i = 1; i <= 12; i++) push(8'(i));
        repeat (30) @(negedge clk);
        check("bp_popped", 32'(rd_ptr - base), 32'd8);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data", m_data, 32'h04030201);
        check("bp_keep", 32'(m_keep), 32'hF);
        repeat (5) @(negedge clk);
        check("bp_hold_data", m_data, 32'h04030201);
        check("bp_hold_popped", 32'(rd_ptr - base), 32'd8);
        m_ready = 1'b1;
        wait_words(c + 3);
        check_word("bp_w1", c, 32'h04030201, 4'hF);
        check_word("bp_w2", c + 1, 32'h08070605, 4'hF);
        check_word("bp_w3", c + 2, 32'h0C0B0A09, 4'hF);

        // Reset mid-word discards the collected lanes.
        c = out_cnt;
        @(negedge clk);
        push(8'hEE);
        push(8'hFF);
        wait_drained();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", 32'(m_valid), 32'd0);
        repeat (10) @(negedge clk);
        check("midrst_cnt", 32'(out_cnt), 32'(c));
        push(8'h31);
        push(8'h32);
        push(8'h33);
        push(8'h34);
        wait_words(c + 1);
        check_word("midrst_word", c, 32'h34333231, 4'hF);

        check("underflow", 32'(underflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
